spi_host: RTL



---
 rtl/spi_host_pkg.sv | 10 +
 rtl/spi_host_if.sv | 17 +
 rtl/spi_host_clkgen.sv | 15 +
 rtl/spi_host.sv | 119 +++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// spi_host_pkg: FSM encoding, SPI mode and command opcodes shared by host and slave
package spi_host_pkg;
  typedef enum logic [2:0] {
    SPI_IDLE, SPI_SETUP, SPI_LOAD, SPI_LOW, SPI_HIGH, SPI_HOLD, SPI_GAP
  } spi_state_e;
  localparam int SPI_MODE = 0;
  localparam logic [7:0] OP_CFG_WR = 8'h01;
  localparam logic [7:0] OP_ADC_RD = 8'h02;
  localparam logic [7:0] OP_DDS_WR = 8'h03;
endpackage

// File: rtl/spi_host_if.sv
// spi_host_if: command, TX stream, RX stream and status handshake of spi_host
interface spi_host_if #(parameter int LEN_W = 12);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  modport master (output cmd_valid, cmd_len, tx_data, tx_valid,
                  input cmd_ready, tx_ready, rx_data, rx_valid, busy, done);
  modport slave (input cmd_valid, cmd_len, tx_data, tx_valid,
                 output cmd_ready, tx_ready, rx_data, rx_valid, busy, done);
endinterface

// File: rtl/spi_host_clkgen.sv
// spi_host_clkgen: sck half-period counter, strobes phase_end on the last cycle of each phase
module spi_host_clkgen #(parameter int CLK_DIV = 4) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic phase_end_o
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign phase_end_o = run_i && cnt_q == CW'(CLK_DIV - 1);
  // restart at every phase boundary and hold at zero while not timing a phase
  always_comb cnt_d = (!run_i || phase_end_o) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/spi_host.sv
// spi_host: SPI mode-0 master framing byte-count transactions with ncs
module spi_host import spi_host_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 12,
  parameter int GAP_CYC = 8
) (
  input  logic      clk,
  input  logic      rst,
  spi_host_if.slave bus,
  output logic      sck_spi,
  output logic      mosi_spi,
  output logic      ncs_spi,
  input  logic      miso_spi
);
  localparam int GW = $clog2(GAP_CYC + 1);
  spi_state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic sck_q, sck_d, ncs_q, ncs_d, mosi_q, mosi_d, rxv_q, rxv_d, done_q, done_d;
  logic s1_q, s2_q, pe, load;
  spi_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk), .rst(rst),
    .run_i(state_q inside {SPI_SETUP, SPI_LOW, SPI_HIGH, SPI_HOLD}),
    .phase_end_o(pe)
  );
  assign load          = state_q == SPI_LOAD && bus.tx_valid;
  assign bus.cmd_ready = state_q == SPI_IDLE;
  assign bus.busy      = state_q != SPI_IDLE;
  assign bus.tx_ready  = load;
  assign bus.rx_data   = rx_q;
  assign bus.rx_valid  = rxv_q;
  assign bus.done      = done_q;
  assign sck_spi       = sck_q;
  assign ncs_spi       = ncs_q;
  assign mosi_spi      = mosi_q;
  // next state, datapath and registered pin values derived from the next state
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    gap_d   = gap_q;
    mosi_d  = mosi_q;
    rxv_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      SPI_IDLE: if (bus.cmd_valid) begin
        len_d   = bus.cmd_len;
        done_d  = bus.cmd_len == '0;
        state_d = bus.cmd_len == '0 ? SPI_IDLE : SPI_SETUP;
      end
      SPI_SETUP: state_d = pe ? SPI_LOAD : SPI_SETUP;
      SPI_LOAD: if (load) begin
        sh_d    = bus.tx_data;
        mosi_d  = bus.tx_data[7];
        state_d = SPI_LOW;
      end
      SPI_LOW: state_d = pe ? SPI_HIGH : SPI_LOW;
      SPI_HIGH: if (pe) begin
        sh_d   = {sh_q[6:0], s2_q};
        mosi_d = sh_q[6];
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          rx_d    = sh_d;
          rxv_d   = 1'b1;
          len_d   = len_q - 1'b1;
          state_d = len_d == '0 ? SPI_HOLD : SPI_LOAD;
        end else state_d = SPI_LOW;
      end
      SPI_HOLD: if (pe) begin
        done_d  = 1'b1;
        gap_d   = '0;
        state_d = SPI_GAP;
      end
      SPI_GAP: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(GAP_CYC - 1) ? SPI_IDLE : SPI_GAP;
      end
      default: state_d = SPI_IDLE;
    endcase
    sck_d = state_d == SPI_HIGH;
    ncs_d = state_d inside {SPI_IDLE, SPI_GAP};
  end
  // state, datapath, pin registers and the two-flop miso synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SPI_IDLE;
      len_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      ncs_q   <= 1'b1;
      mosi_q  <= 1'b0;
      rxv_q   <= 1'b0;
      done_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      ncs_q   <= ncs_d;
      mosi_q  <= mosi_d;
      rxv_q   <= rxv_d;
      done_q  <= done_d;
      s1_q    <= miso_spi;
      s2_q    <= s1_q;
    end
  end
endmodule
